// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : friscv instruction fetch: PC, imem request/response channel,
//            instruction buffer, decode handoff with stall and redirect flush.
//            Optional misaligned-redirect trap under FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        ins_misalign
`endif
);

  localparam int              c_ptr_w   = $clog2(BUF_DEPTH);
  localparam int              c_cnt_w   = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0]     c_nop     = 32'h0000_0013;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(BUF_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [31:0]         r_pc;
  logic [31:0]         r_last_pc;
  logic [31:0]         r_buf_pc   [BUF_DEPTH];
  logic [31:0]         r_buf_data [BUF_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  r_outstanding;
  logic [c_cnt_w-1:0]  r_discard;

  logic                w_credit;
  logic                w_hs;
  logic                w_rsp;
  logic                w_drop;
  logic                w_push;
  logic                w_pop;
  logic                w_misalign;
  logic                w_redirect_misalign;
  logic [31:0]         w_redirect_pc;
  logic [31:0]         w_tag_pc;
  logic [c_cnt_w-1:0]  w_rsp_cnt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_redirect_misalign = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_pc       = redirect_pc;
  assign w_misalign          = r_misalign;
  assign ins_misalign        = r_misalign;

  // Sticky until the next redirect; an aligned one clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (redirect) begin
      r_misalign <= w_redirect_misalign;
    end
  end
`else
  assign w_redirect_misalign = 1'b0;
  assign w_redirect_pc       = redirect_pc & 32'hFFFF_FFFC;
  assign w_misalign          = 1'b0;
`endif

  // Credit covers both buffered words and every request still in flight,
  // including those that will be discarded, so the buffer cannot overflow.
  assign w_credit       = (r_outstanding + r_count) < c_depth;
  assign imem_req_valid = rst_n && !redirect && !w_misalign && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  assign w_rsp     = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_cnt = c_cnt_w'(w_rsp);
  assign w_drop    = w_rsp && (r_discard != '0);
  assign w_push    = w_rsp && !w_drop && !redirect;

  assign ins_valid = (r_count != '0);
  assign w_pop     = ins_valid && !stall;

  // Live requests are contiguous and end at pc-4, so the oldest one's PC
  // follows from the outstanding count once all discards have drained.
  assign w_tag_pc = r_pc - {{(30 - c_cnt_w){1'b0}}, r_outstanding, 2'b00};

  assign ins    = ins_valid ? r_buf_data[r_rd_ptr] : c_nop;
  assign ins_pc = ins_valid ? r_buf_pc[r_rd_ptr]   : r_last_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect) begin
      r_pc          <= w_redirect_pc;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - w_rsp_cnt;
      r_discard     <= r_outstanding - w_rsp_cnt;
    end else begin
      if (w_hs) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_hs && !w_rsp) begin
        r_outstanding <= r_outstanding + c_cnt_one;
      end else if (!w_hs && w_rsp) begin
        r_outstanding <= r_outstanding - c_cnt_one;
      end

      if (w_drop) begin
        r_discard <= r_discard - c_cnt_one;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= w_tag_pc;
      r_buf_data[r_wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_pc <= 32'h0000_0000;
    end else if (redirect && w_redirect_misalign) begin
      r_last_pc <= redirect_pc;
    end else if (ins_valid) begin
      r_last_pc <= r_buf_pc[r_rd_ptr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Randomized and directed self-checking bench for fetch_stage,
//            using a queue-based model of memory and the decode-facing stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 4;
  localparam logic [31:0] c_nop     = 32'h0000_0013;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        ins_misalign;
`endif

  int          tests_run = 0;
  int          fails     = 0;
  int          cyc;
  req_t        mem_q[$];
  ins_t        buf_q[$];
  logic [31:0] obs_pc[$];
  logic [31:0] exp_req_pc;
  logic [31:0] last_pc;
  logic [31:0] mem_xor;
  bit          model_mis;
  int unsigned lat_lo, lat_hi, rsp_pct;
  int          first_hs_cyc, first_valid_cyc, obs_hs;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .ins            (ins),
    .ins_pc         (ins_pc),
    .ins_valid      (ins_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .ins_misalign   (ins_misalign)
`endif
  );

  // One clock: drive memory response, compare against model, advance model.
  task automatic step();
    bit   rsp_now;
    bit   exp_req;
    req_t r;
    rsp_now = 1'b0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < rsp_pct)
      rsp_now = 1'b1;
    imem_rsp_valid = rsp_now;
    if (rsp_now) imem_rsp_data = mem_q[0].addr ^ mem_xor;
    else         imem_rsp_data = $urandom;
    #1;
    exp_req = !redirect && !model_mis && (mem_q.size() + buf_q.size() < BUF_DEPTH);

    tests_run++;
    if (imem_req_valid !== exp_req) begin
      fails++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_req);
    end
    if (exp_req) begin
      tests_run++;
      if (imem_req_addr !== exp_req_pc) begin
        fails++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req_pc);
      end
    end
    tests_run++;
    if (ins_valid !== (buf_q.size() != 0)) begin
      fails++;
      $display("FAIL ins_valid cyc=%0d: got %b expected %b", cyc, ins_valid, buf_q.size() != 0);
    end
    if (buf_q.size() != 0) begin
      tests_run++;
      if (ins !== buf_q[0].data || ins_pc !== buf_q[0].pc) begin
        fails++;
        $display("FAIL ins_head cyc=%0d: got %h/%h expected %h/%h",
                 cyc, ins, ins_pc, buf_q[0].data, buf_q[0].pc);
      end
    end else begin
      tests_run++;
      if (ins !== c_nop || ins_pc !== last_pc) begin
        fails++;
        $display("FAIL ins_empty cyc=%0d: got %h/%h expected %h/%h", cyc, ins, ins_pc, c_nop, last_pc);
      end
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    tests_run++;
    if (ins_misalign !== model_mis) begin
      fails++;
      $display("FAIL ins_misalign cyc=%0d: got %b expected %b", cyc, ins_misalign, model_mis);
    end
`endif

    if (ins_valid === 1'b1 && !stall && !redirect) obs_pc.push_back(ins_pc);
    if (ins_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (imem_req_valid === 1'b1 && imem_req_ready) obs_hs++;

    if (buf_q.size() != 0) last_pc = buf_q[0].pc;
    if (redirect) begin
      if (rsp_now) void'(mem_q.pop_front());
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      buf_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      model_mis  = (redirect_pc[1:0] != 2'b00);
      exp_req_pc = redirect_pc;
      if (model_mis) last_pc = redirect_pc;
`else
      exp_req_pc = {redirect_pc[31:2], 2'b00};
`endif
    end else begin
      if (buf_q.size() != 0 && !stall) void'(buf_q.pop_front());
      if (rsp_now) begin
        r = mem_q.pop_front();
        if (!r.stale) buf_q.push_back('{pc: r.addr, data: r.addr ^ mem_xor});
      end
      if (exp_req && imem_req_ready) begin
        mem_q.push_back('{addr: exp_req_pc, due: cyc + 1 + int'($urandom_range(lat_hi, lat_lo)), stale: 1'b0});
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
    end
    tests_run++;
    if (ins_valid !== 1'b0 || ins !== c_nop || ins_pc !== 32'h0) begin
      fails++; $display("FAIL reset_outputs: got %b/%h/%h expected 0/%h/0", ins_valid, ins, ins_pc, c_nop);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    tests_run++;
    if (ins_misalign !== 1'b0) begin
      fails++; $display("FAIL reset_misalign: got %b expected 0", ins_misalign);
    end
`endif
    mem_q.delete(); buf_q.delete(); obs_pc.delete();
    exp_req_pc = RESET_PC; last_pc = 32'h0; model_mis = 1'b0;
    cyc = 0; first_hs_cyc = -1; first_valid_cyc = -1; obs_hs = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int n0;
    mem_xor = 32'h0; lat_lo = 0; lat_hi = 0; rsp_pct = 100;
    stall = 1'b0; imem_req_ready = 1'b1; redirect = 1'b0;
    for (int i = 0; i < 12; i++) step();
    n0 = obs_pc.size();
    for (int i = 0; i < 10; i++) step();
    tests_run++;
    if (obs_pc.size() < 3) begin
      fails++; $display("FAIL stream_first: got %0d deliveries expected >=3", obs_pc.size());
    end else if (obs_pc[0] !== RESET_PC || obs_pc[1] !== RESET_PC + 32'd4 || obs_pc[2] !== RESET_PC + 32'd8) begin
      fails++; $display("FAIL stream_first: got %h %h %h expected %h %h %h", obs_pc[0], obs_pc[1], obs_pc[2],
                        RESET_PC, RESET_PC + 32'd4, RESET_PC + 32'd8);
    end
    tests_run++;
    if (first_valid_cyc - first_hs_cyc != 2) begin
      fails++; $display("FAIL stream_latency: got %0d expected 2", first_valid_cyc - first_hs_cyc);
    end
    tests_run++;
    if (obs_pc.size() - n0 != 10) begin
      fails++; $display("FAIL stream_rate: got %0d expected 10", obs_pc.size() - n0);
    end
  endtask

  task automatic test_stall();
    int          h0, n0;
    logic [31:0] held_pc;
    held_pc = (buf_q.size() != 0) ? buf_q[0].pc : last_pc;
    h0 = obs_hs;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (ins_pc !== held_pc) begin
        fails++; $display("FAIL stall_hold: got %h expected %h", ins_pc, held_pc);
      end
    end
    tests_run++;
    if (obs_hs - h0 > BUF_DEPTH) begin
      fails++; $display("FAIL stall_credit: got %0d expected <=%0d", obs_hs - h0, BUF_DEPTH);
    end
    stall = 1'b0;
    n0 = obs_pc.size();
    for (int i = 0; i < 8; i++) step();
    tests_run++;
    if (obs_pc.size() < n0 + 2 || obs_pc[n0] !== held_pc || obs_pc[n0+1] !== held_pc + 32'd4) begin
      fails++; $display("FAIL stall_release: got %0d deliveries expected %h then %h", obs_pc.size() - n0,
                        held_pc, held_pc + 32'd4);
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a;
    a = exp_req_pc;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (imem_req_addr !== a) begin
        fails++; $display("FAIL ready_low_addr: got %h expected %h", imem_req_addr, a);
      end
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_wrap();
    int n0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    n0 = obs_pc.size();
    for (int i = 0; i < 30 && obs_pc.size() < n0 + 3; i++) step();
    tests_run++;
    if (obs_pc.size() < n0 + 3) begin
      fails++; $display("FAIL wrap: got %0d deliveries expected 3", obs_pc.size() - n0);
    end else if (obs_pc[n0] !== 32'hFFFF_FFF8 || obs_pc[n0+1] !== 32'hFFFF_FFFC || obs_pc[n0+2] !== 32'h0) begin
      fails++; $display("FAIL wrap: got %h %h %h expected fffffff8 fffffffc 00000000",
                        obs_pc[n0], obs_pc[n0+1], obs_pc[n0+2]);
    end
  endtask

  task automatic test_redirect_stale();
    int n0;
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) step();
    tests_run++;
    if (mem_q.size() < 2) begin
      fails++; $display("FAIL redirect_setup: got %0d in flight expected 2", mem_q.size());
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    n0 = obs_pc.size();
    for (int i = 0; i < 40 && obs_pc.size() <= n0; i++) step();
    tests_run++;
    if (obs_pc.size() <= n0) begin
      fails++; $display("FAIL redirect_first: got timeout expected 00000100");
    end else if (obs_pc[n0] !== 32'h0000_0100) begin
      fails++; $display("FAIL redirect_first: got %h expected 00000100", obs_pc[n0]);
    end
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_redirect_full();
    int n0;
    stall = 1'b1;
    for (int i = 0; i < 20 && !(buf_q.size() == BUF_DEPTH - 1 && mem_q.size() == 1 && mem_q[0].due <= cyc); i++)
      step();
    tests_run++;
    if (!(buf_q.size() == BUF_DEPTH - 1 && mem_q.size() == 1)) begin
      fails++; $display("FAIL full_setup: got %0d/%0d expected %0d/1", buf_q.size(), mem_q.size(), BUF_DEPTH - 1);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect = 1'b0; stall = 1'b0;
    tests_run++;
    if (ins_valid !== 1'b0) begin
      fails++; $display("FAIL full_flush: got %b expected 0", ins_valid);
    end
    n0 = obs_pc.size();
    for (int i = 0; i < 20 && obs_pc.size() <= n0; i++) step();
    tests_run++;
    if (obs_pc.size() <= n0 || obs_pc[n0] !== 32'h0000_0400) begin
      fails++; $display("FAIL full_resume: got %0d deliveries expected first 00000400", obs_pc.size() - n0);
    end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    mem_xor = $urandom; lat_lo = 0; lat_hi = 3; rsp_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      stall          = ($urandom_range(99) < 30);
      imem_req_ready = ($urandom_range(99) < 70);
      redirect       = ($urandom_range(99) < 5);
      rp = $urandom;
      if ($urandom_range(7) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'h3);
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(9) != 0) rp[1:0] = 2'b00;
`endif
      redirect_pc = rp;
      step();
    end
    redirect = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    int n0;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    tests_run++;
    if (ins_misalign !== 1'b1 || ins_pc !== 32'h0000_0102) begin
      fails++; $display("FAIL misalign_set: got %b/%h expected 1/00000102", ins_misalign, ins_pc);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
        fails++; $display("FAIL misalign_noreq: got %b expected 0", imem_req_valid);
      end
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    n0 = obs_pc.size();
    for (int i = 0; i < 20 && obs_pc.size() <= n0; i++) step();
    tests_run++;
    if (obs_pc.size() <= n0 || obs_pc[n0] !== 32'h0000_0200 || ins_misalign !== 1'b0) begin
      fails++; $display("FAIL misalign_clear: got %0d deliveries misalign=%b expected first 00000200 misalign=0",
                        obs_pc.size() - n0, ins_misalign);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_ready_low();
    test_wrap();
    test_redirect_stale();
    test_redirect_full();
    test_random();
    test_reset();
    test_stream();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the friscv pipeline. It sits directly upstream of the decode stage.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small instruction buffer.
- Presents instruction word plus PC to decode, with stall backpressure and branch/jump redirect (flush).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, instruction buffer entries; power of two, 2 or 4; also caps requests in flight.

Ports:
clk  input  1  clock.
rst_n  input  1  reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_req_addr  output  32  fetch address; always equals pc.
imem_rsp_valid  input  1  response valid; in order, one per accepted request, at least 1 cycle after acceptance.
imem_rsp_data  input  32  instruction word.
redirect  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  32  new PC.
stall  input  1  decode cannot accept an instruction this cycle.
ins  output  32  instruction to decode.
ins_pc  output  32  PC of ins.
ins_valid  output  1  ins/ins_pc valid.

Behaviour:
- Reset: rst_n is synchronous and active-low, sampled on clk rising edge. Reset loads:
  - pc=RESET_PC;
  - buffer empty, outstanding=0, discard=0;
  - ins_valid=0, ins=32'h0000_0013 (NOP), ins_pc=0, imem_req_valid=0 for the reset cycle.
  - Reset mid-operation drops all in-flight responses. Memory is reset with the core.
- Internal state: pc; FIFO of {pc,data} with BUF_DEPTH entries; outstanding count and discard count, each 0..BUF_DEPTH.
- Request issue:
  - imem_req_valid = !redirect && (outstanding + occupancy < BUF_DEPTH), evaluated on registered state.
  - On handshake: pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding increments.
  - The tag pc for each request is pushed to an internal tag queue.
- Response:
  - Each response decrements outstanding.
  - If discard>0: discard decrements and the data is dropped.
  - Otherwise {tag pc, data} is written into the FIFO.
  - No combinational bypass. A request accepted at cycle t with response at t+1 gives earliest ins_valid at t+2.
- Output:
  - ins/ins_pc = FIFO head; ins_valid = FIFO not empty.
  - Head is popped when ins_valid && !stall.
  - When empty, ins=NOP and ins_pc holds its last value.
  - With stall=1, outputs are held stable.
- Redirect (priority over everything except reset):
  - Same cycle: no request issued. A response arriving this cycle is dropped.
  - Next cycle: FIFO empty (ins_valid=0) and pc=redirect_pc.
  - discard = outstanding - (imem_rsp_valid ? 1:0). Outstanding is decremented the same way; outstanding entries remain in flight and are later dropped.
  - Requesting resumes the cycle after redirect, at redirect_pc, as soon as credit allows. Credit counts in-flight discarded requests.
- Back-to-back redirects: each recomputes discard from the current outstanding count. The latest redirect_pc wins.
- Simultaneous push and pop on a full FIFO is legal. Occupancy is unchanged.
- Credit rule guarantees no overflow. A response with outstanding=0 is a protocol error: ignored, no state change.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Extra output ins_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets pc=redirect_pc, suppresses all requests and sets ins_misalign=1 from the next cycle.
  - ins_misalign is held until the next aligned redirect or reset. ins_pc=redirect_pc while ins_misalign=1.
- Not defined: port absent; redirect_pc[1:0] is treated as 2'b00.

Test Plan:
1. Reset then release, memory always ready, 1-cycle response returning word=address -> first request addr 0x0; ins_valid rises 2 cycles after first handshake; ins_pc sequence 0x0,0x4,0x8 with ins matching; one instruction per cycle sustained.
2. stall=1 for 5 cycles mid-stream -> ins/ins_pc held; at most BUF_DEPTH requests issued beyond the held instruction; no loss or duplication after release.
3. imem_req_ready=0 for 3 cycles -> imem_req_addr held at same pc; pc advances only on handshake.
4. redirect to 0x100 with 2 outstanding, responses returning 2 cycles later -> both stale responses dropped; next ins_pc=0x100; no instruction from old stream reaches decode.
5. redirect asserted in the same cycle as a response and the FIFO full -> response dropped; ins_valid=0 next cycle; fetch resumes at redirect_pc.
6. With FETCH_MISALIGN_TRAP_EN: redirect_pc=0x102 -> ins_misalign=1 next cycle, no requests issued; an aligned redirect to 0x200 clears it and fetch restarts at 0x200.
